// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  // Width of the channel-select fields on the write and readback ports.
  localparam int unsigned CH_SEL_W = 3;
  // Largest channel count addressable through CH_SEL_W.
  localparam int unsigned MAX_CH   = 8;

  // Default counter/divisor width; holds divisors up to 131071.
  localparam int unsigned DEF_CNT_W = 17;

  // Reference system clock and the legacy 500 Hz output rate.
  localparam int unsigned SYS_CLK_HZ  = 100_000_000;
  localparam int unsigned DEF_OUT_HZ  = 500;

  // Divisor (half-period in input cycles) for a 50% duty output at f_out_hz.
  function automatic int unsigned calc_div(input int unsigned f_in_hz,
                                           input int unsigned f_out_hz);
    if (f_out_hz == 0) begin
      return 0;
    end
    return f_in_hz / (2 * f_out_hz);
  endfunction

  // 100 MHz / (2 * 500 Hz) = 100000.
  localparam int unsigned DEF_DIV_VAL = calc_div(SYS_CLK_HZ, DEF_OUT_HZ);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active divisor, divided clock and rising-edge tick.
module clk_div_chan #(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned DEF_DIV = 100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic [CNT_W-1:0] shadow_div_o,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] ResetDiv = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             halted;
  logic             terminal;

  assign halted   = (active_q == '0);
  assign terminal = (cnt_q == active_q - CNT_W'(1));

  // Next-state: sync_clr beats a restart write to a halted channel, which beats counting.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    clk_d    = clk_q;
    // The shadow register takes every write, whatever else happens this cycle.
    shadow_d = wr_en_i ? wr_div_i : shadow_q;

    if (sync_clr_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (wr_en_i && halted && (wr_div_i != '0)) begin
      // Restart: new divisor is live at once, first toggle after wr_div enabled cycles.
      active_d = wr_div_i;
      cnt_d    = '0;
      clk_d    = 1'b0;
    end else if (!en_i) begin
      // Frozen: counter and level hold.
    end else if (halted) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      // A nonzero shadow that arrived during sync_clr would otherwise never be picked up.
      active_d = shadow_d;
    end else if (terminal) begin
      cnt_d    = '0;
      // shadow_d already carries a same-cycle write, so a colliding write wins.
      active_d = shadow_d;
      // Switching to divisor 0 parks the output low instead of toggling.
      clk_d    = (shadow_d == '0) ? 1'b0 : ~clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    tick_d = clk_d & ~clk_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= ResetDiv;
      active_q <= ResetDiv;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign shadow_div_o = shadow_q;
  assign clk_o        = clk_q;
  assign tick_o       = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode, readback mux and channel array.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                en,
  input  logic                sync_clr,
  input  logic                wr_en,
  input  logic [CH_SEL_W-1:0] wr_ch,
  input  logic [CNT_W-1:0]    wr_div,
  input  logic [CH_SEL_W-1:0] rd_ch,
  output logic [CNT_W-1:0]    rd_div,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick
);

  // Elaboration-time parameter sanity checks.
  if ((N_CH < 1) || (N_CH > MAX_CH)) begin : g_bad_n_ch
    $error("clk_div_multi: N_CH must be in 1..%0d", MAX_CH);
  end
  if ((CNT_W < 32) && (DEF_DIV >= (32'd1 << CNT_W))) begin : g_bad_def_div
    $error("clk_div_multi: DEF_DIV does not fit in CNT_W bits");
  end

  logic [N_CH-1:0]  wr_sel;
  logic [CNT_W-1:0] shadow_div [N_CH];

  // One-hot write select; channel numbers at or above N_CH match nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = wr_en && (wr_ch == CH_SEL_W'(i));
    end
  end

  // Readback of the shadow divisor; unmatched channel numbers read 0.
  always_comb begin
    rd_div = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_SEL_W'(i)) begin
        rd_div = shadow_div[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_i       (clk_in),
      .rst_ni      (reset),
      .en_i        (en),
      .sync_clr_i  (sync_clr),
      .wr_en_i     (wr_sel[g]),
      .wr_div_i    (wr_div),
      .shadow_div_o(shadow_div[g]),
      .clk_o       (clk_out[g]),
      .tick_o      (tick[g])
    );
  end

endmodule
